// File: rtl/console_text_writer_if.sv
// Byte-stream input and text-memory write port of the console text writer.
// The writer owns the slave modport; the byte source / memory side uses master.
interface console_text_writer_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_data, mem_we
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/console_text_writer.sv
// Text cursor and control-code interpreter that turns a byte stream into
// single-cycle writes on the console text memory, including a full-screen clear.
module console_text_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    console_text_writer_if.slave  bus,
    output logic [7:0]            cursor_col,
    output logic [7:0]            cursor_row,
    output logic                  busy
);
    // COLS*ROWS must fit in ADDR_W bits so the clear sweep can reach the last cell.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [7:0]        col_nxt, row_nxt;
    logic              busy_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        data_q, data_nxt;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;

    assign bus.rx_ready = (state == IDLE);
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;

    assign accept   = bus.rx_valid && (state == IDLE);
    assign cur_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            busy       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            busy       <= busy_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = cursor_col;
        row_nxt   = cursor_row;
        busy_nxt  = busy;
        we_nxt    = 1'b0;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
                        // mem_data doubles as the latch for the pending character
                        state_nxt = WRITE;
                        we_nxt    = 1'b1;
                        addr_nxt  = cur_addr;
                        data_nxt  = bus.rx_data;
                    end else begin
                        case (bus.rx_data)
                            8'h0D: col_nxt = '0;
                            8'h0A: row_nxt = (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
                            8'h08: if (cursor_col != 8'd0) col_nxt = cursor_col - 8'd1;
                            8'h0C: begin
                                state_nxt = CLEAR;
                                busy_nxt  = 1'b1;
                                we_nxt    = 1'b1;
                                addr_nxt  = '0;
                                data_nxt  = FILL_CHAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                if (cursor_col == LAST_COL) begin
                    col_nxt = '0;
                    row_nxt = (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
                end else begin
                    col_nxt = cursor_col + 8'd1;
                end
            end
            CLEAR: begin
                // mem_addr is the sweep counter; the write to LAST_ADDR is the final one
                if (addr_q == LAST_ADDR) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end else begin
                    we_nxt   = 1'b1;
                    addr_nxt = addr_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_console_text_writer.sv
// Directed bench for console_text_writer: a screen-level model queues the
// writes each byte must cause and tracks the cursor; a per-cycle checker compares.
module tb_console_text_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] cursor_col, cursor_row;
    logic       busy;

    console_text_writer_if #(.ADDR_W(16)) bus();

    console_text_writer #(.COLS(80), .ROWS(30), .ADDR_W(16), .FILL_CHAR(8'h20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: expected write sequence {addr, data} and cursor position
    logic [23:0] exp_q[$];
    int m_col = 0;
    int m_row = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({16'(m_row * 80 + m_col), b});
            m_col = m_col + 1;
            if (m_col == 80) begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
            end
        end else begin
            case (b)
                8'h0D: m_col = 0;
                8'h0A: m_row = (m_row + 1) % 30;
                8'h08: if (m_col > 0) m_col = m_col - 1;
                8'h0C: begin
                    for (int i = 0; i < 2400; i++) exp_q.push_back({16'(i), 8'h20});
                    m_col = 0;
                    m_row = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.rx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.rx_ready), 32'd1);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        model_byte(b);
        #1 bus.rx_valid = 1'b0;
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(e[23:8]));
                    chk("wr_data", 32'(bus.mem_data), 32'(e[7:0]));
                end
            end else if (bus.rx_ready && exp_q.size() == 0) begin
                chk("cur_col", 32'(cursor_col), 32'(m_col));
                chk("cur_row", 32'(cursor_row), 32'(m_row));
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int n, writes;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we",    32'(bus.mem_we),   32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst_data",  32'(bus.mem_data), 32'd0);
        chk("rst_col",   32'(cursor_col),   32'd0);
        chk("rst_row",   32'(cursor_row),   32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.rx_ready), 32'd1);

        // 'A' at (0,0): write on the next cycle, ready low exactly one cycle
        send(8'h41);
        @(negedge clk);
        chk("a_we",    32'(bus.mem_we),   32'd1);
        chk("a_addr",  32'(bus.mem_addr), 32'd0);
        chk("a_data",  32'(bus.mem_data), 32'h41);
        chk("a_ready", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        chk("a_ready2", 32'(bus.rx_ready), 32'd1);
        chk("a_we2",    32'(bus.mem_we),   32'd0);
        chk("a_col",    32'(cursor_col),   32'd1);
        chk("a_row",    32'(cursor_row),   32'd0);

        // walk to (79,29), then 'Z' lands on the last cell and wraps to (0,0)
        send(8'h0D);
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h2E);
        send(8'h5A);
        @(negedge clk);
        chk("z_we",   32'(bus.mem_we),   32'd1);
        chk("z_addr", 32'(bus.mem_addr), 32'd2399);
        chk("z_data", 32'(bus.mem_data), 32'h5A);
        @(negedge clk);
        chk("z_col", 32'(cursor_col), 32'd0);
        chk("z_row", 32'(cursor_row), 32'd0);

        // to (5,3), then CR / LF / BS at column 0
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        send(8'h0D);
        @(negedge clk);
        chk("cr_col", 32'(cursor_col), 32'd0);
        chk("cr_row", 32'(cursor_row), 32'd3);
        send(8'h0A);
        @(negedge clk);
        chk("lf_col", 32'(cursor_col), 32'd0);
        chk("lf_row", 32'(cursor_row), 32'd4);
        send(8'h08);
        @(negedge clk);
        chk("bs0_col", 32'(cursor_col), 32'd0);
        chk("bs0_row", 32'(cursor_row), 32'd4);
        send(8'h71);
        send(8'h08);
        @(negedge clk);
        chk("bs1_col", 32'(cursor_col), 32'd0);

        // ignored codes are accepted in one cycle with no effect
        send(8'h00);
        send(8'h7F);
        send(8'hFF);
        @(negedge clk);
        chk("drop_ready", 32'(bus.rx_ready), 32'd1);
        chk("drop_col",   32'(cursor_col),   32'd0);
        chk("drop_row",   32'(cursor_row),   32'd4);

        // clear screen with 'B' held on the source throughout
        send(8'h0C);
        bus.rx_data  = 8'h42;
        bus.rx_valid = 1'b1;
        model_byte(8'h42);
        @(negedge clk);
        chk("clr_busy",  32'(busy),         32'd1);
        chk("clr_ready", 32'(bus.rx_ready), 32'd0);
        n = 0;
        writes = 0;
        while (busy && n < 3000) begin
            if (bus.mem_we) writes++;
            n++;
            @(negedge clk);
        end
        chk("clr_cycles", 32'(n),      32'd2400);
        chk("clr_writes", 32'(writes), 32'd2400);
        chk("clr_ready2", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("b_we",   32'(bus.mem_we),   32'd1);
        chk("b_addr", 32'(bus.mem_addr), 32'd0);
        chk("b_data", 32'(bus.mem_data), 32'h42);
        @(negedge clk);
        chk("b_col", 32'(cursor_col), 32'd1);
        chk("b_row", 32'(cursor_row), 32'd0);

        // reset after 1000 clear writes aborts the sweep
        send(8'h0C);
        n = 0;
        writes = 0;
        while (writes < 1000 && n < 3000) begin
            @(negedge clk);
            if (bus.mem_we) writes++;
            n++;
        end
        chk("mid_writes", 32'(writes), 32'd1000);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we",   32'(bus.mem_we),   32'd0);
        chk("ar_busy", 32'(busy),         32'd0);
        chk("ar_col",  32'(cursor_col),   32'd0);
        chk("ar_row",  32'(cursor_row),   32'd0);
        chk("ar_addr", 32'(bus.mem_addr), 32'd0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready", 32'(bus.rx_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("ar_busy2", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
